// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 4-stage (F, D, E, M) 16-bit pipeline.
// Resolves load-use hazards, taken branches, multi-cycle memory waits and
// HALT. Also keeps a saturating stall-cycle counter and a sticky memory
// timeout flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal flow; hazards are evaluated with MW > branch > LU > halt
// FLUSH    | extra squash cycles after a taken branch (FLUSH_CYCLES > 1)
// MEM_WAIT | pipeline frozen until memory ready or timeout
// HALT     | fetch/decode held, bubbles into E until resume

module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             rs_addD,
    input  logic [3:0]             rt_addD,
    input  logic                   uses_rsD,
    input  logic                   uses_rtD,
    input  logic                   halt_instD,
    input  logic [3:0]             rd_addE,
    input  logic                   mem_readE,
    input  logic                   branch_takenE,
    input  logic                   mem_reqM,
    input  logic                   mem_readyM,
    input  logic                   resume,
    output logic                   pc_enF,
    output logic                   pc_selF,
    output logic                   dec_enD,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   ex_enE,
    output logic [2:0]             state_o,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   mem_timeout
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_FLUSH    = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_HALT     = 3'd3
    } state_t;

    // The branch cycle itself is the first flush cycle, so FLUSH holds one fewer.
    localparam logic [3:0]             FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0]             TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE   = 1;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX   = '1;

    state_t                   state_q, state_n;
    logic [3:0]               fcnt_q, fcnt_n;
    logic [7:0]               tcnt_q, tcnt_n;
    logic [STALL_CNT_W-1:0]   stall_q;
    logic                     timeout_q;
    logic                     set_timeout;
    logic                     lu;
    logic                     mw;

    // Hazard terms; r0 is hardwired zero so it never creates a load-use.
    always_comb begin
        lu = mem_readE && (rd_addE != 4'd0) &&
             ((uses_rsD && (rs_addD == rd_addE)) ||
              (uses_rtD && (rt_addD == rd_addE)));
        mw = mem_reqM && !mem_readyM;
    end

    // Next-state and control-output decode.
    always_comb begin
        pc_enF      = 1'b1;
        pc_selF     = 1'b0;
        dec_enD     = 1'b1;
        flushD      = 1'b0;
        flushE      = 1'b0;
        ex_enE      = 1'b1;
        state_n     = state_q;
        fcnt_n      = fcnt_q;
        tcnt_n      = tcnt_q;
        set_timeout = 1'b0;

        case (state_q)
            S_RUN: begin
                if (mw) begin
                    pc_enF  = 1'b0;
                    dec_enD = 1'b0;
                    ex_enE  = 1'b0;
                    state_n = S_MEM_WAIT;
                    tcnt_n  = 8'd1;
                end else if (branch_takenE) begin
                    pc_selF = 1'b1;
                    flushD  = 1'b1;
                    flushE  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_n = S_FLUSH;
                        fcnt_n  = FLUSH_INIT;
                    end
                end else if (lu) begin
                    pc_enF  = 1'b0;
                    dec_enD = 1'b0;
                    flushE  = 1'b1;
                end else if (halt_instD) begin
                    pc_enF  = 1'b0;
                    dec_enD = 1'b0;
                    flushE  = 1'b1;
                    state_n = S_HALT;
                end
            end

            S_FLUSH: begin
                if (mw) begin
                    // Wrong-path work is already squashed; drop the rest of the flush.
                    pc_enF  = 1'b0;
                    dec_enD = 1'b0;
                    ex_enE  = 1'b0;
                    state_n = S_MEM_WAIT;
                    tcnt_n  = 8'd1;
                    fcnt_n  = 4'd0;
                end else begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                    if (fcnt_q <= 4'd1) begin
                        state_n = S_RUN;
                        fcnt_n  = 4'd0;
                    end else begin
                        fcnt_n = fcnt_q - 4'd1;
                    end
                end
            end

            S_MEM_WAIT: begin
                pc_enF  = 1'b0;
                dec_enD = 1'b0;
                ex_enE  = 1'b0;
                if (mem_readyM) begin
                    // Access completes this cycle with the pipeline advancing.
                    pc_enF  = 1'b1;
                    dec_enD = 1'b1;
                    ex_enE  = 1'b1;
                    state_n = S_RUN;
                    tcnt_n  = 8'd0;
                end else if (tcnt_q >= TIMEOUT_LIM) begin
                    set_timeout = 1'b1;
                    state_n     = S_RUN;
                    tcnt_n      = 8'd0;
                end else begin
                    tcnt_n = tcnt_q + 8'd1;
                end
            end

            S_HALT: begin
                pc_enF  = 1'b0;
                dec_enD = 1'b0;
                flushE  = 1'b1;
                ex_enE  = !mw;
                if (resume) begin
                    // HALT still sits in D; replace it with a NOP as fetch restarts.
                    pc_enF  = 1'b1;
                    dec_enD = 1'b1;
                    flushD  = 1'b1;
                    state_n = S_RUN;
                end
            end

            default: begin
                state_n = S_RUN;
                fcnt_n  = 4'd0;
                tcnt_n  = 8'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            fcnt_q  <= 4'd0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_n;
            fcnt_q  <= fcnt_n;
            tcnt_q  <= tcnt_n;
        end
    end

    // Saturating stall counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!pc_enF && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_ONE;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign state_o      = state_q;
    assign stall_cycles = stall_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share stimulus:
// dut (FLUSH_CYCLES=2, MEM_TIMEOUT=255, 16-bit counter) and dut_t
// (FLUSH_CYCLES=1, MEM_TIMEOUT=4, 3-bit counter to reach saturation).

module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rs_addD, rt_addD, rd_addE;
    logic       uses_rsD, uses_rtD, halt_instD, mem_readE;
    logic       branch_takenE, mem_reqM, mem_readyM, resume;

    logic        pc_enF, pc_selF, dec_enD, flushD, flushE, ex_enE, mem_timeout;
    logic [2:0]  state_o;
    logic [15:0] stall_cycles;

    logic        t_pc_enF, t_pc_selF, t_dec_enD, t_flushD, t_flushE, t_ex_enE, t_mem_timeout;
    logic [2:0]  t_state_o;
    logic [2:0]  t_stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .rs_addD(rs_addD), .rt_addD(rt_addD), .uses_rsD(uses_rsD), .uses_rtD(uses_rtD),
        .halt_instD(halt_instD), .rd_addE(rd_addE), .mem_readE(mem_readE),
        .branch_takenE(branch_takenE), .mem_reqM(mem_reqM), .mem_readyM(mem_readyM),
        .resume(resume),
        .pc_enF(pc_enF), .pc_selF(pc_selF), .dec_enD(dec_enD), .flushD(flushD),
        .flushE(flushE), .ex_enE(ex_enE), .state_o(state_o),
        .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .STALL_CNT_W(3)) dut_t (
        .clk(clk), .reset(reset),
        .rs_addD(rs_addD), .rt_addD(rt_addD), .uses_rsD(uses_rsD), .uses_rtD(uses_rtD),
        .halt_instD(halt_instD), .rd_addE(rd_addE), .mem_readE(mem_readE),
        .branch_takenE(branch_takenE), .mem_reqM(mem_reqM), .mem_readyM(mem_readyM),
        .resume(resume),
        .pc_enF(t_pc_enF), .pc_selF(t_pc_selF), .dec_enD(t_dec_enD), .flushD(t_flushD),
        .flushE(t_flushE), .ex_enE(t_ex_enE), .state_o(t_state_o),
        .stall_cycles(t_stall_cycles), .mem_timeout(t_mem_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        rs_addD = 4'd0; rt_addD = 4'd0; rd_addE = 4'd0;
        uses_rsD = 1'b0; uses_rtD = 1'b0; halt_instD = 1'b0; mem_readE = 1'b0;
        branch_takenE = 1'b0; mem_reqM = 1'b0; mem_readyM = 1'b0; resume = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // reset state
        check("rst_state", state_o, 0);
        check("rst_pc_en", pc_enF, 1);
        check("rst_dec_en", dec_enD, 1);
        check("rst_ex_en", ex_enE, 1);
        check("rst_pc_sel", pc_selF, 0);
        check("rst_flushD", flushD, 0);
        check("rst_flushE", flushE, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_timeout", mem_timeout, 0);

        // load-use on rs
        mem_readE = 1; rd_addE = 4'd3; rs_addD = 4'd3; uses_rsD = 1;
        #1;
        check("lu_pc_en", pc_enF, 0);
        check("lu_dec_en", dec_enD, 0);
        check("lu_flushE", flushE, 1);
        check("lu_ex_en", ex_enE, 1);
        tick();
        idle();
        #1;
        check("lu_state", state_o, 0);
        check("lu_stall", stall_cycles, 1);
        check("lu_clear_pc_en", pc_enF, 1);

        // load-use on rt
        mem_readE = 1; rd_addE = 4'd5; rt_addD = 4'd5; uses_rtD = 1;
        #1;
        check("lu_rt_pc_en", pc_enF, 0);
        tick();
        // r0 never hazards; unused source never hazards
        rd_addE = 4'd0; rt_addD = 4'd0; rs_addD = 4'd0; uses_rsD = 1;
        #1;
        check("lu_r0_pc_en", pc_enF, 1);
        rd_addE = 4'd7; rs_addD = 4'd7; uses_rsD = 0; uses_rtD = 0;
        #1;
        check("lu_unused_pc_en", pc_enF, 1);
        idle();
        #1;
        check("lu_stall2", stall_cycles, 2);

        // taken branch, FLUSH_CYCLES=2 on dut, 1 on dut_t
        branch_takenE = 1;
        #1;
        check("br_pc_sel", pc_selF, 1);
        check("br_pc_en", pc_enF, 1);
        check("br_flushD", flushD, 1);
        check("br_flushE", flushE, 1);
        tick();
        branch_takenE = 0;
        #1;
        check("br_state1", state_o, 1);
        check("br_c2_pc_sel", pc_selF, 0);
        check("br_c2_flushD", flushD, 1);
        check("br_c2_flushE", flushE, 1);
        check("br_t_state", t_state_o, 0);
        check("br_t_flushD", t_flushD, 0);
        tick();
        check("br_state0", state_o, 0);
        check("br_end_flushD", flushD, 0);
        check("br_stall", stall_cycles, 2);

        // branch and load-use together: branch wins
        branch_takenE = 1; mem_readE = 1; rd_addE = 4'd2; rs_addD = 4'd2; uses_rsD = 1;
        #1;
        check("brlu_pc_en", pc_enF, 1);
        check("brlu_pc_sel", pc_selF, 1);
        check("brlu_flushD", flushD, 1);
        tick();
        idle();
        tick();
        check("brlu_stall", stall_cycles, 2);

        // memory wait: 5 frozen cycles then ready
        do_reset();
        mem_reqM = 1; mem_readyM = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mw_pc_en", pc_enF, 0);
            check("mw_dec_en", dec_enD, 0);
            check("mw_ex_en", ex_enE, 0);
            if (i > 0) check("mw_state", state_o, 2);
            tick();
        end
        mem_readyM = 1;
        #1;
        check("mw_rdy_state", state_o, 2);
        check("mw_rdy_pc_en", pc_enF, 1);
        check("mw_rdy_ex_en", ex_enE, 1);
        tick();
        idle();
        #1;
        check("mw_end_state", state_o, 0);
        check("mw_stall", stall_cycles, 5);
        check("mw_timeout", mem_timeout, 0);

        // timeout on dut_t (MEM_TIMEOUT=4)
        do_reset();
        mem_reqM = 1; mem_readyM = 0;
        tick();
        check("to_enter", t_state_o, 2);
        tick(); tick(); tick();
        check("to_pre_state", t_state_o, 2);
        check("to_pre_flag", t_mem_timeout, 0);
        tick();
        idle();
        #1;
        check("to_state", t_state_o, 0);
        check("to_flag", t_mem_timeout, 1);
        check("to_stall", t_stall_cycles, 5);
        tick(); tick();
        check("to_sticky", t_mem_timeout, 1);
        do_reset();
        check("to_rst_clear", t_mem_timeout, 0);

        // ready in the timeout cycle wins
        mem_reqM = 1; mem_readyM = 0;
        tick(); tick(); tick(); tick();
        mem_readyM = 1;
        tick();
        idle();
        #1;
        check("to_race_state", t_state_o, 0);
        check("to_race_flag", t_mem_timeout, 0);

        // HALT, then reset mid-HALT
        do_reset();
        halt_instD = 1;
        #1;
        check("halt_pc_en", pc_enF, 0);
        check("halt_flushE0", flushE, 1);
        tick();
        halt_instD = 0;
        #1;
        check("halt_state", state_o, 3);
        check("halt_flushE1", flushE, 1);
        check("halt_dec_en", dec_enD, 0);
        tick();
        check("halt_flushE2", flushE, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("halt_rst_state", state_o, 0);
        check("halt_rst_stall", stall_cycles, 0);
        check("halt_rst_pc_en", pc_enF, 1);

        // HALT, then resume
        halt_instD = 1;
        tick();
        halt_instD = 0;
        tick();
        check("hr_state", state_o, 3);
        resume = 1;
        #1;
        check("hr_flushD", flushD, 1);
        check("hr_pc_en", pc_enF, 1);
        tick();
        resume = 0;
        #1;
        check("hr_end_state", state_o, 0);
        check("hr_end_flushD", flushD, 0);
        check("hr_stall", stall_cycles, 2);

        // resume outside HALT does nothing
        resume = 1;
        #1;
        check("res_run_flushD", flushD, 0);
        tick();
        resume = 0;
        #1;
        check("res_run_state", state_o, 0);

        // stall counter saturation (3-bit on dut_t)
        do_reset();
        halt_instD = 1;
        tick();
        halt_instD = 0;
        for (int i = 0; i < 9; i++) tick();
        check("sat_t_stall", t_stall_cycles, 7);
        check("sat_stall", stall_cycles, 10);

        // MW in HALT: E held, state stays HALT
        mem_reqM = 1; mem_readyM = 0;
        #1;
        check("hmw_ex_en", ex_enE, 0);
        tick();
        check("hmw_state", state_o, 3);
        mem_readyM = 1;
        #1;
        check("hmw_rdy_ex_en", ex_enE, 1);
        idle();

        // MW during FLUSH discards the rest of the flush
        do_reset();
        branch_takenE = 1;
        tick();
        branch_takenE = 0;
        mem_reqM = 1;
        #1;
        check("fmw_pc_en", pc_enF, 0);
        check("fmw_flushD", flushD, 0);
        tick();
        check("fmw_state", state_o, 2);
        mem_readyM = 1;
        tick();
        idle();
        #1;
        check("fmw_end_state", state_o, 0);
        check("fmw_end_flushD", flushD, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
